// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - in-flight destination tracker: stall / register-file read / forward-from-stage-k
//
// Purpose:
//   Remembers the destination register of every instruction between issue and
//   write-back (stage 1 = youngest, stage PIPE_DEPTH = write-back). For the
//   instruction sitting in the issue register it decides, per source operand,
//   whether to read the register file, forward from stage k, or stall.
//
// Ports:
//   clk                clock, rising edge
//   rst                asynchronous reset, active-low
//   issue_valid        instruction present in the issue register
//   issue_src0_valid   operand 0 is read
//   issue_src0         operand 0 register
//   issue_src1_valid   operand 1 is read
//   issue_src1         operand 1 register
//   issue_dst_valid    instruction writes a register
//   issue_dst          destination register
//   issue_dst_is_load  destination is written from memory
//   flush              squash all tracked entries
//   stall              hold the issue register and insert a bubble
//   issue_accept       issue_valid & ~stall & ~flush
//   fwd_sel0/fwd_sel1  0 = register file, k = forward from stage k
//   pending_count      number of valid tracked entries
//   stall_cycles       saturating count of cycles with stall asserted

module pipeline_scoreboard #(
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int PIPE_DEPTH       = 3,
    parameter int FORWARD_EN       = 1,
    parameter int LOAD_READY_STAGE = 3,
    parameter int ZERO_REG_HARD    = 0,
    localparam int SEL_W           = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_src0_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_src0,
    input  logic                      issue_src1_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_src1,
    input  logic                      issue_dst_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_dst,
    input  logic                      issue_dst_is_load,
    input  logic                      flush,
    output logic                      stall,
    output logic                      issue_accept,
    output logic [SEL_W-1:0]          fwd_sel0,
    output logic [SEL_W-1:0]          fwd_sel1,
    output logic [SEL_W-1:0]          pending_count,
    output logic [31:0]               stall_cycles
);

    // Tracked entries, index 1 = youngest.
    logic [PIPE_DEPTH:1]       ent_valid;
    logic [PIPE_DEPTH:1]       ent_load;
    logic [REG_ADDR_WIDTH-1:0] ent_dst [1:PIPE_DEPTH];

    // Per-source youngest-match results.
    logic             hit0, hit1;
    logic             ready0, ready1;
    logic [SEL_W-1:0] k0, k1;
    logic             hazard0, hazard1;

    // Youngest match search. The loop walks from oldest to youngest so the
    // last assignment wins, which shadows any older producer of the same
    // register. Register 0 is ignored entirely when it is hardwired.
    always_comb begin
        hit0   = 1'b0;
        ready0 = 1'b0;
        k0     = '0;
        hit1   = 1'b0;
        ready1 = 1'b0;
        k1     = '0;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (issue_src0_valid && ent_valid[k] && (ent_dst[k] == issue_src0) &&
                !((ZERO_REG_HARD != 0) && (issue_src0 == '0))) begin
                hit0   = 1'b1;
                ready0 = !ent_load[k] || (k >= LOAD_READY_STAGE);
                k0     = SEL_W'(k);
            end
            if (issue_src1_valid && ent_valid[k] && (ent_dst[k] == issue_src1) &&
                !((ZERO_REG_HARD != 0) && (issue_src1 == '0))) begin
                hit1   = 1'b1;
                ready1 = !ent_load[k] || (k >= LOAD_READY_STAGE);
                k1     = SEL_W'(k);
            end
        end
    end

    // Without forwarding every match is a hazard; with forwarding only a
    // load result that has not reached its ready stage is.
    always_comb begin
        hazard0  = 1'b0;
        hazard1  = 1'b0;
        fwd_sel0 = '0;
        fwd_sel1 = '0;
        if (FORWARD_EN == 0) begin
            hazard0 = hit0;
            hazard1 = hit1;
        end else begin
            hazard0 = hit0 && !ready0;
            hazard1 = hit1 && !ready1;
            if (hit0 && ready0) begin
                fwd_sel0 = k0;
            end
            if (hit1 && ready1) begin
                fwd_sel1 = k1;
            end
        end
    end

    assign stall        = issue_valid && (hazard0 || hazard1);
    assign issue_accept = issue_valid && !stall && !flush;

    always_comb begin
        pending_count = '0;
        for (int k = 1; k <= PIPE_DEPTH; k++) begin
            pending_count = pending_count + SEL_W'(ent_valid[k]);
        end
    end

    // Entries advance every cycle regardless of stall: a stalled issue slot
    // injects a bubble, so older producers keep draining toward write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid    <= '0;
            ent_load     <= '0;
            stall_cycles <= '0;
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                ent_dst[k] <= '0;
            end
        end else begin
            if (flush) begin
                ent_valid <= '0;
            end else begin
                ent_valid[1] <= issue_accept && issue_dst_valid;
                for (int k = 2; k <= PIPE_DEPTH; k++) begin
                    ent_valid[k] <= ent_valid[k-1];
                end
            end
            ent_dst[1]  <= issue_dst;
            ent_load[1] <= issue_dst_is_load;
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                ent_dst[k]  <= ent_dst[k-1];
                ent_load[k] <= ent_load[k-1];
            end
            if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb/tb_pipeline_scoreboard.sv - scoreboard bench for pipeline_scoreboard

module tb_pipeline_scoreboard;

    localparam int X = -1;

    typedef struct packed {
        logic       v;
        logic       s0v;
        logic [4:0] s0;
        logic       s1v;
        logic [4:0] s1;
        logic       dv;
        logic [4:0] d;
        logic       ld;
        logic       fl;
    } in_t;

    typedef struct {
        int    inst;
        string nm;
        int    st;
        int    acc;
        int    s0;
        int    s1;
        int    pend;
        int    scyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    in_t  nf_in;
    in_t  fw_in;

    logic        nf_stall, nf_acc, fw_stall, fw_acc;
    logic [1:0]  nf_sel0, nf_sel1, nf_pend, fw_sel0, fw_sel1, fw_pend;
    logic [31:0] nf_scyc, fw_scyc;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_scoreboard #(
        .REG_ADDR_WIDTH(5), .PIPE_DEPTH(3), .FORWARD_EN(0),
        .LOAD_READY_STAGE(3), .ZERO_REG_HARD(0)
    ) u_nf (
        .clk(clk), .rst(rst),
        .issue_valid(nf_in.v),
        .issue_src0_valid(nf_in.s0v), .issue_src0(nf_in.s0),
        .issue_src1_valid(nf_in.s1v), .issue_src1(nf_in.s1),
        .issue_dst_valid(nf_in.dv), .issue_dst(nf_in.d),
        .issue_dst_is_load(nf_in.ld), .flush(nf_in.fl),
        .stall(nf_stall), .issue_accept(nf_acc),
        .fwd_sel0(nf_sel0), .fwd_sel1(nf_sel1),
        .pending_count(nf_pend), .stall_cycles(nf_scyc)
    );

    pipeline_scoreboard #(
        .REG_ADDR_WIDTH(5), .PIPE_DEPTH(3), .FORWARD_EN(1),
        .LOAD_READY_STAGE(2), .ZERO_REG_HARD(1)
    ) u_fw (
        .clk(clk), .rst(rst),
        .issue_valid(fw_in.v),
        .issue_src0_valid(fw_in.s0v), .issue_src0(fw_in.s0),
        .issue_src1_valid(fw_in.s1v), .issue_src1(fw_in.s1),
        .issue_dst_valid(fw_in.dv), .issue_dst(fw_in.d),
        .issue_dst_is_load(fw_in.ld), .flush(fw_in.fl),
        .stall(fw_stall), .issue_accept(fw_acc),
        .fwd_sel0(fw_sel0), .fwd_sel1(fw_sel1),
        .pending_count(fw_pend), .stall_cycles(fw_scyc)
    );

    function automatic in_t mk(input logic v, input logic s0v, input int s0,
                               input logic s1v, input int s1, input logic dv,
                               input int d, input logic ld, input logic fl);
        in_t r;
        r.v   = v;
        r.s0v = s0v;
        r.s0  = 5'(s0);
        r.s1v = s1v;
        r.s1  = 5'(s1);
        r.dv  = dv;
        r.d   = 5'(d);
        r.ld  = ld;
        r.fl  = fl;
        return r;
    endfunction

    function automatic exp_t mke(input int inst, input string nm, input int st,
                                 input int acc, input int s0, input int s1,
                                 input int pend, input int scyc);
        exp_t e;
        e.inst = inst;
        e.nm   = nm;
        e.st   = st;
        e.acc  = acc;
        e.s0   = s0;
        e.s1   = s1;
        e.pend = pend;
        e.scyc = scyc;
        return e;
    endfunction

    // Drive one cycle on one instance (the other idles) and queue what that
    // cycle's combinational outputs must be.
    task automatic step(input int inst, input string nm, input in_t in,
                        input int st, input int acc, input int s0, input int s1,
                        input int pend, input int scyc);
        @(posedge clk);
        #1;
        nf_in = '0;
        fw_in = '0;
        if (inst == 0) nf_in = in;
        else           fw_in = in;
        q.push_back(mke(inst, nm, st, acc, s0, s1, pend, scyc));
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        if (expv >= 0) begin
            checks++;
            if (act != expv) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d", nm, act, expv);
            end
        end
    endtask

    // Monitor: pops every queued expectation mid-cycle and compares.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.inst == 0) begin
                chk({e.nm, ".stall"},  int'(nf_stall), e.st);
                chk({e.nm, ".accept"}, int'(nf_acc),   e.acc);
                chk({e.nm, ".sel0"},   int'(nf_sel0),  e.s0);
                chk({e.nm, ".sel1"},   int'(nf_sel1),  e.s1);
                chk({e.nm, ".pend"},   int'(nf_pend),  e.pend);
                chk({e.nm, ".scyc"},   int'(nf_scyc),  e.scyc);
            end else begin
                chk({e.nm, ".stall"},  int'(fw_stall), e.st);
                chk({e.nm, ".accept"}, int'(fw_acc),   e.acc);
                chk({e.nm, ".sel0"},   int'(fw_sel0),  e.s0);
                chk({e.nm, ".sel1"},   int'(fw_sel1),  e.s1);
                chk({e.nm, ".pend"},   int'(fw_pend),  e.pend);
                chk({e.nm, ".scyc"},   int'(fw_scyc),  e.scyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        nf_in = '0;
        fw_in = '0;
        #1;
        q.push_back(mke(0, "rst_nf", 0, 0, 0, 0, 0, 0));
        q.push_back(mke(1, "rst_fw", 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Forwarding instance: ALU forwarding, load latency, shadowing, r0, flush.
        step(1, "f0_alu_r3",  mk(1,0,0, 0,0, 1,3, 0,0),  0,1,0,0,0,0);
        step(1, "f1_use_k1",  mk(1,1,3, 0,0, 0,0, 0,0),  0,1,1,0,1,0);
        step(1, "f2_use_k2",  mk(1,1,3, 0,0, 0,0, 0,0),  0,1,2,0,1,0);
        step(1, "f3_use_k3",  mk(1,0,0, 1,3, 0,0, 0,0),  0,1,0,3,1,0);
        step(1, "f4_retired", mk(1,1,3, 0,0, 0,0, 0,0),  0,1,0,0,0,0);
        step(1, "f5_load_r4", mk(1,0,0, 0,0, 1,4, 1,0),  0,1,0,0,0,0);
        step(1, "f6_ld_stall",mk(1,0,0, 1,4, 0,0, 0,0),  1,0,0,0,1,0);
        step(1, "f7_ld_fwd",  mk(1,0,0, 1,4, 0,0, 0,0),  0,1,0,2,1,1);
        step(1, "f8_r5",      mk(1,0,0, 0,0, 1,5, 0,0),  0,1,0,0,1,1);
        step(1, "f9_r9",      mk(1,0,0, 0,0, 1,9, 0,0),  0,1,0,0,1,1);
        step(1, "f10_r5",     mk(1,0,0, 0,0, 1,5, 0,0),  0,1,0,0,2,1);
        step(1, "f11_shadow", mk(1,1,5, 1,5, 0,0, 0,0),  0,1,1,1,3,1);
        step(1, "f12_r0",     mk(1,0,0, 0,0, 1,0, 0,0),  0,1,0,0,2,1);
        step(1, "f13_zero",   mk(1,1,0, 1,0, 0,0, 0,0),  0,1,0,0,2,1);
        step(1, "f14_r10",    mk(1,0,0, 0,0, 1,10,0,0),  0,1,0,0,1,1);
        step(1, "f15_r11",    mk(1,0,0, 0,0, 1,11,0,0),  0,1,0,0,2,1);
        step(1, "f16_r12",    mk(1,0,0, 0,0, 1,12,0,0),  0,1,0,0,2,1);
        step(1, "f17_flush",  mk(1,1,12,0,0, 1,13,0,1),  0,0,1,0,3,1);
        step(1, "f18_after",  mk(1,1,12,0,0, 1,13,0,0),  0,1,0,0,0,1);

        // No-forwarding instance: stall until the producer retires.
        step(0, "n0_alu_r3",  mk(1,0,0, 0,0, 1,3, 0,0),  0,1,0,0,0,0);
        step(0, "n1_stall",   mk(1,1,3, 0,0, 1,6, 0,0),  1,0,0,0,1,0);
        step(0, "n2_stall",   mk(1,1,3, 0,0, 1,6, 0,0),  1,0,0,0,1,1);
        step(0, "n3_stall",   mk(1,1,3, 0,0, 1,6, 0,0),  1,0,0,0,1,2);
        step(0, "n4_accept",  mk(1,1,3, 0,0, 1,6, 0,0),  0,1,0,0,0,3);
        step(0, "n5_r1",      mk(1,0,0, 0,0, 1,1, 0,0),  0,1,0,0,1,3);
        step(0, "n6_r2",      mk(1,0,0, 0,0, 1,2, 0,0),  0,1,0,0,2,3);
        step(0, "n7_r7",      mk(1,0,0, 0,0, 1,7, 0,0),  0,1,0,0,3,3);
        step(0, "n8_r8",      mk(1,0,0, 0,0, 1,8, 0,0),  0,1,0,0,3,3);

        // Asynchronous reset mid-cycle with three live entries.
        @(posedge clk);
        #1;
        nf_in = mk(1,1,8, 0,0, 0,0, 0,0);
        fw_in = '0;
        rst   = 1'b0;
        q.push_back(mke(0, "n9_async_rst", 0, X, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
